// File: rtl/program_launcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : program_launcher
// Brief    : Resets a processor once, then starts and times a run of up to
//            four programs. Each run ends on a qualified ack or on a timeout.
// Revision : 1.0 - initial release
// ============================================================================
module program_launcher #(
  parameter int          RESET_CYCLES = 2,
  parameter int          START_CYCLES = 2,
  parameter logic [15:0] TIMEOUT      = 16'd50000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Go,
  input  logic [1:0]  NumProgs,
  input  logic        DutAck,
  output logic        DutReset,
  output logic        DutStart,
  output logic [1:0]  ProgIdx,
  output logic        Busy,
  output logic [15:0] RunCycles,
  output logic        RunValid,
  output logic        Done,
  output logic        Timeout
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRESET = 3'd1,
    S_START  = 3'd2,
    S_RUN    = 3'd3,
    S_NEXT   = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  localparam logic [15:0] C_RESET_LAST = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] C_START_LAST = 16'(START_CYCLES - 1);

  state_t      r_state;
  logic [1:0]  r_num_last;
  logic [15:0] r_phase;
  logic [15:0] r_cycle_cnt;
  logic        r_armed;
  logic [15:0] w_cnt_inc;

  // Count including the current RUN cycle; never exceeds TIMEOUT.
  assign w_cnt_inc = r_cycle_cnt + 16'd1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_num_last  <= 2'd0;
      r_phase     <= 16'd0;
      r_cycle_cnt <= 16'd0;
      r_armed     <= 1'b0;
      DutReset    <= 1'b0;
      DutStart    <= 1'b0;
      ProgIdx     <= 2'd0;
      Busy        <= 1'b0;
      RunCycles   <= 16'd0;
      RunValid    <= 1'b0;
      Done        <= 1'b0;
      Timeout     <= 1'b0;
    end else begin
      RunValid <= 1'b0;
      Done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Go) begin
            r_state    <= S_DRESET;
            r_num_last <= NumProgs;
            ProgIdx    <= 2'd0;
            Timeout    <= 1'b0;
            DutReset   <= 1'b1;
            Busy       <= 1'b1;
            r_phase    <= 16'd0;
          end
        end

        S_DRESET: begin
          if (r_phase == C_RESET_LAST) begin
            DutReset <= 1'b0;
            DutStart <= 1'b1;
            r_phase  <= 16'd0;
            r_state  <= S_START;
          end else begin
            r_phase <= r_phase + 16'd1;
          end
        end

        S_START: begin
          r_cycle_cnt <= 16'd0;
          r_armed     <= 1'b0;
          if (r_phase == C_START_LAST) begin
            DutStart <= 1'b0;
            r_state  <= S_RUN;
          end else begin
            r_phase <= r_phase + 16'd1;
          end
        end

        S_RUN: begin
          r_cycle_cnt <= w_cnt_inc;
          // An ack only counts after the processor has dropped it once.
          if (!DutAck) begin
            r_armed <= 1'b1;
          end
          if (DutAck && r_armed) begin
            RunCycles <= w_cnt_inc;
            RunValid  <= 1'b1;
            r_state   <= S_NEXT;
          end else if (w_cnt_inc >= TIMEOUT) begin
            RunCycles <= TIMEOUT;
            RunValid  <= 1'b1;
            Timeout   <= 1'b1;
            Done      <= 1'b1;
            r_state   <= S_FIN;
          end
        end

        S_NEXT: begin
          if (ProgIdx == r_num_last) begin
            Done    <= 1'b1;
            r_state <= S_FIN;
          end else begin
            ProgIdx  <= ProgIdx + 2'd1;
            DutStart <= 1'b1;
            r_phase  <= 16'd0;
            r_state  <= S_START;
          end
        end

        S_FIN: begin
          Busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          Busy     <= 1'b0;
          DutReset <= 1'b0;
          DutStart <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/program_launcher.md
PROGRAM_LAUNCHER -- requirements
Module: program_launcher

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 2, number of cycles DutReset is held high.
REQ-002 SHALL have parameter START_CYCLES, default 2, number of cycles DutStart is held high per program.
REQ-003 SHALL have parameter TIMEOUT, default 16'd50000, maximum RUN cycles before abort.
REQ-004 SHALL have port Clk, input, 1, the single clock; all logic on posedge.
REQ-005 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port Go, input, 1, request to run a program sequence.
REQ-007 SHALL have port NumProgs, input, 2, index of last program to run (runs NumProgs+1 programs).
REQ-008 SHALL have port DutAck, input, 1, done flag from processor.
REQ-009 SHALL have port DutReset, output, 1, processor reset.
REQ-010 SHALL have port DutStart, output, 1, processor start.
REQ-011 SHALL have port ProgIdx, output, 2, index of current program.
REQ-012 SHALL have port Busy, output, 1, high in every state except IDLE.
REQ-013 SHALL have port RunCycles, output, 16, RUN-cycle count of last finished program.
REQ-014 SHALL have port RunValid, output, 1, one-cycle pulse when RunCycles updates.
REQ-015 SHALL have port Done, output, 1, one-cycle pulse at sequence end.
REQ-016 SHALL have port Timeout, output, 1, sticky abort flag.

Function
REQ-017 SHALL implement states IDLE, DRESET, START, RUN, NEXT, FIN; all outputs registered.
REQ-018 IDLE: DutReset=0, DutStart=0; Go=1 -> DRESET, latch NumProgs, ProgIdx=0, Timeout=0.
REQ-019 Go SHALL be ignored in every state except IDLE; NumProgs changes after acceptance SHALL have no effect.
REQ-020 DRESET: DutReset=1 for exactly RESET_CYCLES cycles, then -> START.
REQ-021 START: DutStart=1 for exactly START_CYCLES cycles; cycle counter cleared to 0; ack-arm flag cleared; DutAck ignored; then -> RUN.
REQ-022 RUN: DutStart=0; counter +1 per cycle; arm flag set the first cycle DutAck=0.
REQ-023 RUN: DutAck=1 while armed -> RunCycles=counter value in that cycle, RunValid=1 next cycle, -> NEXT.
REQ-024 RUN: DutAck=1 while not armed (stale halt from previous program) SHALL NOT terminate the run.
REQ-025 RUN: counter reaching TIMEOUT with no qualified ack -> Timeout=1, RunCycles=TIMEOUT, RunValid pulse, -> FIN (remaining programs skipped).
REQ-026 Qualified ack and timeout in the same cycle SHALL resolve as ack (Timeout stays 0).
REQ-027 NEXT: ProgIdx==latched NumProgs -> FIN; else ProgIdx+1 -> START; no DutReset between programs.
REQ-028 FIN: Done=1 for one cycle, -> IDLE; ProgIdx, RunCycles, Timeout hold until next accepted Go.
REQ-029 Counter SHALL be 16 bits and never wrap (TIMEOUT bound applies first).

Reset
REQ-030 Reset=1 on any edge SHALL force IDLE within one cycle, overriding all other inputs, including mid-RUN.
REQ-031 Reset values: DutReset=0, DutStart=0, ProgIdx=0, Busy=0, RunCycles=0, RunValid=0, Done=0, Timeout=0, counter=0, arm=0.
REQ-032 Reset SHALL NOT be propagated to DutReset; only DRESET drives DutReset.

Verification
REQ-033 Go pulse, NumProgs=0, DutAck low then high 37 cycles after DutStart falls -> DutReset 2 cycles, DutStart 2 cycles, RunCycles=37, one RunValid, one Done, Timeout=0.
REQ-034 NumProgs=2, acks after 10/20/30 RUN cycles -> ProgIdx 0,1,2, RunCycles 10,20,30 with three RunValid pulses, single DutReset burst, one Done.
REQ-035 DutAck held 1 through START and first 3 RUN cycles, low 5 cycles, then 1 -> run not terminated early; RunCycles=9.
REQ-036 TIMEOUT=100, DutAck never high, NumProgs=3 -> Timeout=1, RunCycles=100, ProgIdx stays 0, Done pulse, no further DutStart.
REQ-037 Reset asserted mid-RUN of program 1 -> next cycle IDLE, all outputs at reset values; subsequent Go restarts from ProgIdx=0.
REQ-038 Go pulsed during RUN with NumProgs changed -> ignored; sequence length unchanged; Busy stays 1 until Done.
